// File: rtl/snoop_responder.sv
// Direct-mapped one-word-line cache snoop responder (MSI) with a local fill/write port.
// Optional saturating snoop-hit counter enabled by defining SNOOP_STATS_EN.
module snoop_responder #(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  bus_operation_in,
  input  logic [31:0] bus_address_in,
  output logic        cache_hit_out,
  output logic [31:0] bus_data_out,
  output logic        flush_out,
  output logic        snoop_busy,
  input  logic        local_we,
  input  logic [31:0] local_address,
  input  logic [31:0] local_data,
  input  logic [1:0]  local_state,
  output logic        local_stall,
  output logic [1:0]  local_state_out,
  output logic [15:0] snoop_hit_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_UPGR = 2'b01;
  localparam logic [1:0] OP_RDX  = 2'b10;
  localparam logic [1:0] OP_NONE = 2'b11;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    RESPOND = 2'd2
  } fsm_t;

  logic [TAG_W-1:0] tag_mem [LINES];
  logic [31:0]      data_mem [LINES];
  logic [1:0]       line_state_reg [LINES];

  fsm_t             fsm_reg, fsm_next;
  logic             capture;
  logic [1:0]       op_reg;
  logic [IDX_W-1:0] cap_idx_reg;
  logic [TAG_W-1:0] cap_tag_reg;

  logic [IDX_W-1:0] bus_idx, local_idx;
  logic [TAG_W-1:0] bus_tag, local_tag;
  logic             local_wr;
  logic [1:0]       local_state_norm;

  logic [1:0]       look_state;
  logic [TAG_W-1:0] look_tag;
  logic [31:0]      look_data;
  logic             look_hit;

  logic             resp_hit, resp_flush, resp_upd;
  logic [31:0]      resp_data;
  logic [1:0]       resp_state;
  logic             upd_reg;
  logic [1:0]       new_state_reg;

  logic             unused_addr_bits;

  assign bus_idx   = bus_address_in[2+IDX_W-1:2];
  assign bus_tag   = bus_address_in[31:2+IDX_W];
  assign local_idx = local_address[2+IDX_W-1:2];
  assign local_tag = local_address[31:2+IDX_W];
  assign unused_addr_bits = ^{bus_address_in[1:0], local_address[1:0]};

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm_reg <= IDLE;
    else       fsm_reg <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm_reg;
    capture  = 1'b0;
    case (fsm_reg)
      IDLE: begin
        if (bus_operation_in != OP_NONE) begin
          fsm_next = LOOKUP;
          capture  = 1'b1;
        end
      end
      LOOKUP:  fsm_next = RESPOND;
      RESPOND: fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  assign snoop_busy = (fsm_reg != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg      <= OP_NONE;
      cap_idx_reg <= '0;
      cap_tag_reg <= '0;
    end else if (capture) begin
      op_reg      <= bus_operation_in;
      cap_idx_reg <= bus_idx;
      cap_tag_reg <= bus_tag;
    end
  end

  // Local writes that collide with the line under snoop are dropped; the core retries.
  assign local_stall      = local_we && snoop_busy && (local_idx == cap_idx_reg);
  assign local_wr         = local_we && !local_stall;
  assign local_state_norm = (local_state == 2'b11) ? ST_I : local_state;

  assign local_state_out = (tag_mem[local_idx] == local_tag) ? line_state_reg[local_idx] : ST_I;

  assign look_state = line_state_reg[cap_idx_reg];
  assign look_tag   = tag_mem[cap_idx_reg];
  assign look_data  = data_mem[cap_idx_reg];
  assign look_hit   = (look_state != ST_I) && (look_tag == cap_tag_reg);

  // BusUpgr on an M line is a protocol error and is answered like BusRdX.
  always_comb begin
    resp_hit   = 1'b0;
    resp_flush = 1'b0;
    resp_data  = '0;
    resp_upd   = 1'b0;
    resp_state = ST_I;
    if (look_hit) begin
      case (op_reg)
        OP_RD: begin
          resp_hit   = 1'b1;
          resp_data  = look_data;
          resp_flush = (look_state == ST_M);
          resp_upd   = (look_state == ST_M);
          resp_state = ST_S;
        end
        OP_UPGR, OP_RDX: begin
          resp_upd   = 1'b1;
          resp_state = ST_I;
          if (op_reg == OP_RDX || look_state == ST_M) begin
            resp_hit   = 1'b1;
            resp_data  = look_data;
            resp_flush = (look_state == ST_M);
          end
        end
        default: ;
      endcase
    end
  end

  // Response registers are loaded on LOOKUP->RESPOND and cleared on the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_hit_out <= 1'b0;
      bus_data_out  <= '0;
      flush_out     <= 1'b0;
      upd_reg       <= 1'b0;
      new_state_reg <= ST_I;
    end else if (fsm_reg == LOOKUP) begin
      cache_hit_out <= resp_hit;
      bus_data_out  <= resp_data;
      flush_out     <= resp_flush;
      upd_reg       <= resp_upd;
      new_state_reg <= resp_state;
    end else begin
      cache_hit_out <= 1'b0;
      bus_data_out  <= '0;
      flush_out     <= 1'b0;
      upd_reg       <= 1'b0;
      new_state_reg <= ST_I;
    end
  end

  // Line state: snoop update and local write never target the same index in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) line_state_reg[i] <= ST_I;
    end else begin
      if (fsm_reg == RESPOND && upd_reg) line_state_reg[cap_idx_reg] <= new_state_reg;
      if (local_wr) line_state_reg[local_idx] <= local_state_norm;
    end
  end

  always_ff @(posedge clk) begin
    if (local_wr) begin
      tag_mem[local_idx]  <= local_tag;
      data_mem[local_idx] <= local_data;
    end
  end

`ifdef SNOOP_STATS_EN
  logic [15:0] hit_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hit_count_reg <= '0;
    else if (fsm_reg == RESPOND && cache_hit_out && hit_count_reg != 16'hFFFF)
      hit_count_reg <= hit_count_reg + 16'd1;
  end

  assign snoop_hit_count = hit_count_reg;
`else
  assign snoop_hit_count = 16'h0000;
`endif

endmodule

// File: doc/snoop_responder.md
SNOOP_RESPONDER -- requirements
Module: snoop_responder

Interface
REQ-001 SHALL have parameter LINES, default 64, number of direct-mapped one-word lines (power of two, 2..1024).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port bus_operation_in  input  2  snooped operation: 00 BusRd, 01 BusUpgr, 10 BusRdX, 11 none.
REQ-005 SHALL have port bus_address_in  input  32  snooped word address.
REQ-006 SHALL have port cache_hit_out  output  1  snoop hit, this cache supplies data.
REQ-007 SHALL have port bus_data_out  output  32  supplied line data.
REQ-008 SHALL have port flush_out  output  1  supplied line was Modified; L2 must absorb data.
REQ-009 SHALL have port snoop_busy  output  1  snoop in progress; new operations ignored.
REQ-010 SHALL have ports local_we (input 1), local_address (input 32), local_data (input 32), local_state (input 2: 00 I, 01 S, 10 M): local fill/write port.
REQ-011 SHALL have port local_stall  output  1  local write rejected this cycle; core retries.
REQ-012 SHALL have port local_state_out  output  2  combinational state of local_address line (I on tag mismatch).
REQ-013 SHALL have port snoop_hit_count  output  16  saturating snoop-hit counter (see Configuration).

Function
REQ-014 Address split SHALL be: index = address[2+log2(LINES)-1:2], tag = address[31:2+log2(LINES)].
REQ-015 FSM SHALL have states IDLE, LOOKUP, RESPOND; IDLE->LOOKUP on edge with bus_operation_in != 11 (op, address captured); LOOKUP->RESPOND unconditionally; RESPOND->IDLE unconditionally.
REQ-016 snoop_busy SHALL be 1 exactly in LOOKUP and RESPOND; operations presented outside IDLE are ignored, not queued.
REQ-017 Hit SHALL be computed in LOOKUP as stored state != I and stored tag == captured tag.
REQ-018 cache_hit_out, bus_data_out, flush_out SHALL be registered, nonzero only in RESPOND (exactly one cycle, two edges after capture), else 0.
REQ-019 BusRd hit on M: hit 1, data = line, flush 1, M->S.
REQ-020 BusRd hit on S: hit 1, data = line, flush 0, remains S.
REQ-021 BusRdX hit on M: hit 1, data, flush 1, ->I; on S: hit 1, data, flush 0, ->I.
REQ-022 BusUpgr hit on S: hit 0, data 0, flush 0, ->I; on M (protocol error): handled as BusRdX.
REQ-023 Miss: hit 0, data 0, flush 0, no state change.
REQ-024 State update SHALL take effect on the RESPOND->IDLE edge.
REQ-025 local_we with no stall SHALL write tag, data, state at index on the same edge; local_state 11 SHALL be written as I.
REQ-026 local_stall = local_we and FSM in LOOKUP/RESPOND and local index == captured index; stalled write discarded.
REQ-027 Requester SHALL return bus_operation_in to 11 in the RESPOND cycle; an op still present in IDLE is a new snoop.

Reset
REQ-028 Reset SHALL asynchronously force FSM IDLE, all line states I, all outputs 0, snoop_hit_count 0; tag/data arrays need not reset.
REQ-029 Reset mid-snoop SHALL abort it with no response pulse and no state update.

Configuration
REQ-030 Macro SNOOP_STATS_EN defined: snoop_hit_count increments by 1 on each RESPOND cycle with cache_hit_out=1, saturates at 0xFFFF.
REQ-031 SNOOP_STATS_EN undefined: counter absent, snoop_hit_count tied to 0; all other behaviour identical.

Verification
REQ-032 Local write addr 0x0000_1004, data 0xDEAD_BEEF, state M; BusRd 0x0000_1004 -> RESPOND: hit 1, data 0xDEAD_BEEF, flush 1; local_state_out then 01.
REQ-033 Line S at 0x0000_2008; BusRdX -> hit 1, data supplied, flush 0; afterwards local_state_out 00.
REQ-034 Line S; BusUpgr same address -> hit 0, data 0, flush 0; state becomes I.
REQ-035 BusRd 0x0000_1104 (same index as 0x0000_1004, tag differs) -> miss, outputs 0, line keeps M; new op during busy ignored.
REQ-036 local_we to captured index during LOOKUP -> local_stall 1, array unchanged; reset asserted in LOOKUP -> no response, counter 0, all lines I.
